maxpool_window_buffer: RTL and testbench
========================================

// Module: maxpool_window_buffer
// PURPOSE
//  Upstream feeder for the Maxpool stage. Accepts a raster-order pixel stream, one pixel per
//  valid cycle, and assembles non-overlapping STRIDE x STRIDE pooling windows. Each complete
//  window is presented as one packed word on window_out with a one-cycle window_valid strobe.
//  window_out connects directly to Maxpool data_in, and window_valid to data_in_valid.
// PARAMETERS
//  STRIDE_SIZE  2   window edge and pooling stride (>=2)
//  DATA_WIDTH   16  pixel width, fixed-point, passed through unmodified
//  ROW_SIZE     4   pixels per image row (image width)
//  COLUMN_SIZE  4   rows per image (image height)
// PORTS
//  clock         in   1                            single clock, rising edge
//  reset         in   1                            asynchronous, active-high
//  pixel_in      in   DATA_WIDTH                   streamed pixel
//  pixel_valid   in   1                            pixel_in accepted on this edge
//  window_out    out  STRIDE_SIZE^2*DATA_WIDTH     packed window
//  window_valid  out  1                            window_out valid, one-cycle pulse
//  frame_done    out  1                            pulses together with the last window of a frame
// BEHAVIOUR
//  - Reset (asynchronous assert, synchronous release): col_cnt=0, row_cnt=0, window_out=0,
//    window_valid=0, frame_done=0. Line-buffer RAM contents are not cleared.
//  - No backpressure. Every pixel_valid cycle consumes exactly one pixel. Idle cycles
//    (pixel_valid=0) hold all state and drive window_valid=0.
//  - Counters: col_cnt runs 0..ROW_SIZE-1. On wrap to 0, row_cnt increments over
//    0..COLUMN_SIZE-1. On accepting pixel (COLUMN_SIZE-1, ROW_SIZE-1), both counters return to 0
//    for the next frame.
//  - Storage: STRIDE_SIZE-1 line buffers, each ROW_SIZE deep. A pixel with
//    (row_cnt % STRIDE_SIZE) = k < STRIDE_SIZE-1 is written to line k at address col_cnt.
//    The current row's last STRIDE_SIZE-1 pixels are held in a shift register.
//  - Emit condition: a pixel accepted with col_cnt % S = S-1 and row_cnt % S = S-1
//    (S = STRIDE_SIZE), col_cnt <= (ROW_SIZE/S)*S-1 and row_cnt <= (COLUMN_SIZE/S)*S-1.
//    On the next rising edge: window_valid=1 and window_out is loaded.
//    Latency: 1 clock from the accepting edge to the window_valid edge.
//  - Packing: element k = r*S + c sits at window_out[k*DATA_WIDTH +: DATA_WIDTH].
//    r = window row (0 = top/oldest); c = window column (0 = leftmost).
//  - Trailing columns or rows beyond a multiple of S are still counted but never produce a window.
//  - window_out holds its last value while window_valid=0.
//  - frame_done=1 in the same cycle as the window_valid of the final full window of the frame.
//  - Pixel accepted on the cycle a window is emitted: handled normally. Back-to-back windows are
//    impossible for S>=2; the pipeline has no stall.
//  - Reset mid-frame: counters restart at (0,0) and any in-flight window is dropped.
//    Stale line data is never emitted, because a window needs S-1 freshly written rows.
// STRUCTURE
//  - Shared package cnn_pkg: DATA_WIDTH, STRIDE_SIZE defaults, and the window packing index
//    function win_idx(r,c)=r*S+c. The same function is used by Maxpool.
//  - Sub-module maxpool_line_buffer: ROW_SIZE x DATA_WIDTH simple-dual-port RAM, one write
//    port plus one combinational read port. S-1 instances.
//  - Top level: counters, emit decode, current-row shift register, output register.
// TESTING
//  1. S=2, 4x4, pixels 1..16 with continuous valid -> 4 windows. Window 1 = 0x0006_0005_0002_0001,
//     1 cycle after pixel 6. Then {8,7,4,3}, {14,13,10,9}, {16,15,12,11}.
//     frame_done only with the last window.
//  2. Same stream with pixel_valid deasserted every other cycle -> identical windows.
//     Each window is delayed to 1 clock after its trigger pixel; no extra valids.
//  3. Two frames back-to-back (1..16, then 17..32) -> second frame's first window is {22,21,18,17}.
//     Counters wrap with no gap cycle.
//  4. ROW_SIZE=5, COLUMN_SIZE=5, S=2, pixels 1..25 -> exactly 4 windows:
//     {8,7,3,2,...} ordering check -> first = {7,6,2,1}. Column 5 and row 5 are never emitted.
//  5. Assert reset after pixel 7 of frame 1, then stream 1..16 -> no window from the aborted
//     frame. Outputs are 0 during reset. Windows then match scenario 1.
//  6. Negative values (S=2): pixels -1..-4 as 2x2 -> window_out elements are sign-exact
//     0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default pixel width, pooling stride and the
// window element packing order used by both the window buffer and Maxpool.
package cnn_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_STRIDE_SIZE = 2;

  // Row-major element index within an s x s window; row 0 is the oldest image row.
  function automatic int win_idx(input int r, input int c, input int s);
    return r * s + c;
  endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// One image row of pixel storage: a single write port and a combinational read port.
module maxpool_line_buffer #(
  parameter int unsigned ROW_SIZE   = 4,
  parameter int unsigned DATA_WIDTH = 16,
  localparam int unsigned AddrWidth = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AddrWidth-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AddrWidth-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [ROW_SIZE];

  // Contents are deliberately left uncleared on reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool_window_buffer.sv
// Assembles non-overlapping STRIDE x STRIDE pooling windows from a raster pixel stream
// and presents each as one packed word with a single-cycle valid strobe.
module maxpool_window_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned STRIDE_SIZE = DEF_STRIDE_SIZE,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ROW_SIZE    = 4,
  parameter int unsigned COLUMN_SIZE = 4
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [DATA_WIDTH-1:0]                        pixel_in,
  input  logic                                         pixel_valid,
  output logic [STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                         window_valid,
  output logic                                         frame_done
);

  localparam int unsigned S  = STRIDE_SIZE;
  localparam int unsigned CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned RW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
  localparam int unsigned PW = $clog2(S);
  localparam int unsigned WW = S * S * DATA_WIDTH;

  localparam logic [CW-1:0] ColLast = CW'(ROW_SIZE - 1);
  localparam logic [CW-1:0] ColFull = CW'((ROW_SIZE / S) * S - 1);
  localparam logic [RW-1:0] RowLast = RW'(COLUMN_SIZE - 1);
  localparam logic [RW-1:0] RowFull = RW'((COLUMN_SIZE / S) * S - 1);
  localparam logic [PW-1:0] PhLast  = PW'(S - 1);

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [PW-1:0] col_ph_q, col_ph_d;
  logic [PW-1:0] row_ph_q, row_ph_d;
  logic [WW-1:0] window_q, window_d, win_next;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          emit;

  logic [DATA_WIDTH-1:0] col_val [S];
  logic [DATA_WIDTH-1:0] sreg_q  [S][S-1];
  logic [DATA_WIDTH-1:0] sreg_d  [S][S-1];

  // Rows 0..S-2 of a window come from the line buffers, read at the current column.
  for (genvar k = 0; k < S - 1; k++) begin : g_line
    maxpool_line_buffer #(
      .ROW_SIZE   (ROW_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_line (
      .clk_i   (clock),
      .we_i    (pixel_valid && (row_ph_q == PW'(k))),
      .waddr_i (col_cnt_q),
      .wdata_i (pixel_in),
      .raddr_i (col_cnt_q),
      .rdata_o (col_val[k])
    );
  end
  assign col_val[S-1] = pixel_in;

  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    col_ph_d  = col_ph_q;
    row_ph_d  = row_ph_q;
    if (pixel_valid) begin
      if (col_cnt_q == ColLast) begin
        col_cnt_d = '0;
        col_ph_d  = '0;
        if (row_cnt_q == RowLast) begin
          row_cnt_d = '0;
          row_ph_d  = '0;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
          row_ph_d  = (row_ph_q == PhLast) ? '0 : row_ph_q + 1'b1;
        end
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
        col_ph_d  = (col_ph_q == PhLast) ? '0 : col_ph_q + 1'b1;
      end
    end
  end

  // Each window row keeps its last S-1 columns; the newest column is live this cycle.
  always_comb begin
    sreg_d = sreg_q;
    if (pixel_valid) begin
      for (int r = 0; r < int'(S); r++) begin
        for (int j = 0; j < int'(S) - 2; j++) begin
          sreg_d[r][j] = sreg_q[r][j+1];
        end
        sreg_d[r][S-2] = col_val[r];
      end
    end
  end

  always_comb begin
    win_next = '0;
    for (int r = 0; r < int'(S); r++) begin
      for (int c = 0; c < int'(S) - 1; c++) begin
        win_next[win_idx(r, c, int'(S))*DATA_WIDTH +: DATA_WIDTH] = sreg_q[r][c];
      end
      win_next[win_idx(r, int'(S) - 1, int'(S))*DATA_WIDTH +: DATA_WIDTH] = col_val[r];
    end
  end

  always_comb begin
    emit = pixel_valid && (col_ph_q == PhLast) && (row_ph_q == PhLast) &&
           (col_cnt_q <= ColFull) && (row_cnt_q <= RowFull);
    window_d = emit ? win_next : window_q;
    valid_d  = emit;
    done_d   = emit && (col_cnt_q == ColFull) && (row_cnt_q == RowFull);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      col_ph_q  <= '0;
      row_ph_q  <= '0;
      window_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      col_ph_q  <= col_ph_d;
      row_ph_q  <= row_ph_d;
      window_q  <= window_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    sreg_q <= sreg_d;
  end

  assign window_out   = window_q;
  assign window_valid = valid_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_maxpool_window_buffer.sv
// Scoreboard bench for maxpool_window_buffer: 4x4, 5x5 and 2x2 instances, all S=2.
module tb_maxpool_window_buffer;

  typedef struct {
    logic [63:0] win;
    logic        fd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pix [3];
  logic        vld [3];
  logic [63:0] wout [3];
  logic        wv [3];
  logic        fd [3];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rows [3] = '{4, 5, 2};
  int          cols [3] = '{4, 5, 2};
  int          mr [3];
  int          mc [3];
  logic [15:0] img [3][5][5];
  exp_t        sbq [3][$];
  logic [63:0] seen [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool_window_buffer #(
    .STRIDE_SIZE (2), .DATA_WIDTH (16), .ROW_SIZE (4), .COLUMN_SIZE (4)
  ) u_a (
    .clock (clk), .reset (rst), .pixel_in (pix[0]), .pixel_valid (vld[0]),
    .window_out (wout[0]), .window_valid (wv[0]), .frame_done (fd[0])
  );

  maxpool_window_buffer #(
    .STRIDE_SIZE (2), .DATA_WIDTH (16), .ROW_SIZE (5), .COLUMN_SIZE (5)
  ) u_b (
    .clock (clk), .reset (rst), .pixel_in (pix[1]), .pixel_valid (vld[1]),
    .window_out (wout[1]), .window_valid (wv[1]), .frame_done (fd[1])
  );

  maxpool_window_buffer #(
    .STRIDE_SIZE (2), .DATA_WIDTH (16), .ROW_SIZE (2), .COLUMN_SIZE (2)
  ) u_c (
    .clock (clk), .reset (rst), .pixel_in (pix[2]), .pixel_valid (vld[2]),
    .window_out (wout[2]), .window_valid (wv[2]), .frame_done (fd[2])
  );

  // Output monitor: every strobe must match the oldest expected window, in the right cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      if (!rst && wv[s]) begin
        seen[s].push_back(wout[s]);
        if (sbq[s].size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_window dut%0d got %h expected no window", s, wout[s]);
        end else begin
          e = sbq[s].pop_front();
          total += 3;
          if (wout[s] !== e.win) begin
            bad++;
            $display("FAIL window dut%0d got %h expected %h", s, wout[s], e.win);
          end
          if (fd[s] !== e.fd) begin
            bad++;
            $display("FAIL frame_done dut%0d got %b expected %b", s, fd[s], e.fd);
          end
          if (cyc !== e.cyc) begin
            bad++;
            $display("FAIL latency dut%0d got cycle %0d expected %0d", s, cyc, e.cyc);
          end
        end
      end else if (!rst && fd[s]) begin
        total++; bad++;
        $display("FAIL frame_done_no_valid dut%0d got 1 expected 0", s);
      end
    end
  end

  task automatic model_clear(input int s);
    mr[s] = 0;
    mc[s] = 0;
    sbq[s].delete();
    seen[s].delete();
  endtask

  task automatic drive(input int s, input logic [15:0] p, input logic v);
    exp_t e;
    int   r;
    int   c;
    @(posedge clk);
    #1;
    pix[s] = p;
    vld[s] = v;
    if (v) begin
      r = mr[s];
      c = mc[s];
      img[s][r][c] = p;
      if ((r % 2 == 1) && (c % 2 == 1) && (r < (rows[s] / 2) * 2) && (c < (cols[s] / 2) * 2))
      begin
        e.win = {img[s][r][c], img[s][r][c-1], img[s][r-1][c], img[s][r-1][c-1]};
        e.fd  = (r == (rows[s] / 2) * 2 - 1) && (c == (cols[s] / 2) * 2 - 1);
        e.cyc = cyc + 1;
        sbq[s].push_back(e);
      end
      if (c == cols[s] - 1) begin
        mc[s] = 0;
        mr[s] = (r == rows[s] - 1) ? 0 : r + 1;
      end else begin
        mc[s] = c + 1;
      end
    end
  endtask

  task automatic idle(input int s, input int n);
    for (int i = 0; i < n; i++) drive(s, 16'h0000, 1'b0);
  endtask

  task automatic check_drained(input int s, input int nwin, input string name);
    total += 2;
    if (sbq[s].size() != 0) begin
      bad++;
      $display("FAIL %s_missing dut%0d got %0d pending expected 0", name, s, sbq[s].size());
    end
    if (seen[s].size() != nwin) begin
      bad++;
      $display("FAIL %s_count dut%0d got %0d windows expected %0d", name, s, seen[s].size(), nwin);
    end
  endtask

  task automatic check_seen(input int s, input int idx, input logic [63:0] exp,
                            input string name);
    total++;
    if (seen[s].size() <= idx) begin
      bad++;
      $display("FAIL %s dut%0d got no window %0d expected %h", name, s, idx, exp);
    end else if (seen[s][idx] !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got %h expected %h", name, s, seen[s][idx], exp);
    end
  endtask

  task automatic test_reset();
    #2;
    for (int s = 0; s < 3; s++) begin
      total += 3;
      if (wout[s] !== 64'h0) begin
        bad++; $display("FAIL reset_window dut%0d got %h expected 0", s, wout[s]);
      end
      if (wv[s] !== 1'b0) begin
        bad++; $display("FAIL reset_valid dut%0d got %b expected 0", s, wv[s]);
      end
      if (fd[s] !== 1'b0) begin
        bad++; $display("FAIL reset_frame_done dut%0d got %b expected 0", s, fd[s]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    model_clear(0);
    for (int i = 1; i <= 16; i++) drive(0, 16'(i), 1'b1);
    idle(0, 3);
    check_drained(0, 4, "basic");
    check_seen(0, 0, 64'h0006_0005_0002_0001, "basic_first");
    check_seen(0, 3, 64'h0010_000F_000C_000B, "basic_last");
  endtask

  task automatic test_gaps();
    model_clear(0);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 16'(i), 1'b1);
      drive(0, 16'hDEAD, 1'b0);
    end
    idle(0, 3);
    check_drained(0, 4, "gaps");
    check_seen(0, 1, 64'h0008_0007_0004_0003, "gaps_second");
    check_seen(0, 2, 64'h000E_000D_000A_0009, "gaps_third");
  endtask

  task automatic test_back_to_back();
    model_clear(0);
    for (int i = 1; i <= 32; i++) drive(0, 16'(i), 1'b1);
    idle(0, 3);
    check_drained(0, 8, "b2b");
    check_seen(0, 4, 64'h0016_0015_0012_0011, "b2b_frame2_first");
  endtask

  task automatic test_odd_size();
    model_clear(1);
    for (int i = 1; i <= 25; i++) drive(1, 16'(i), 1'b1);
    idle(1, 3);
    check_drained(1, 4, "odd");
    check_seen(1, 0, 64'h0007_0006_0002_0001, "odd_first");
    check_seen(1, 3, 64'h0013_0012_000E_000D, "odd_last");
  endtask

  task automatic test_reset_mid();
    model_clear(0);
    for (int i = 1; i <= 7; i++) drive(0, 16'(i), 1'b1);
    drive(0, 16'h0000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total += 2;
    if (wout[0] !== 64'h0) begin
      bad++; $display("FAIL midreset_window got %h expected 0", wout[0]);
    end
    if (wv[0] !== 1'b0 || fd[0] !== 1'b0) begin
      bad++; $display("FAIL midreset_strobes got %b%b expected 00", wv[0], fd[0]);
    end
    model_clear(0);
    idle(0, 2);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) drive(0, 16'(i), 1'b1);
    idle(0, 3);
    check_drained(0, 4, "midreset");
    check_seen(0, 0, 64'h0006_0005_0002_0001, "midreset_first");
  endtask

  task automatic test_negative();
    model_clear(2);
    for (int i = 1; i <= 4; i++) drive(2, 16'(-i), 1'b1);
    idle(2, 3);
    check_drained(2, 1, "neg");
    check_seen(2, 0, 64'hFFFC_FFFD_FFFE_FFFF, "neg_window");
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      pix[s] = '0;
      vld[s] = 1'b0;
      mr[s]  = 0;
      mc[s]  = 0;
    end
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_odd_size();
    test_reset_mid();
    test_negative();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
